// File: rtl/vector_register_file_seq.sv
// Vector register file with LMUL grouping, two registered read ports,
// a multi-beat masked write-back port and a reservation scoreboard.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   vlmul, op0_sel, op1_sel  read group size and base registers
//   op0_out, op1_out         registered read data, reg base+k at [k*REG_W +: REG_W]
//   wb_valid, wb_ready       write-back handshake
//   wb_sel, wb_vlmul         write-back base register and group size
//   wb_mask, wb_in           per-register write enables and group data
//   wb_done                  pulse after the last beat of a group commits
//   rsv_valid, rsv_sel,      reserve a group (sets its busy bits)
//   rsv_vlmul
//   busy                     per-register pending-write flags
//   misalign                 pulse: accepted wb or rsv base was not aligned
//   dbg_regs                 flat view of all registers
module vector_register_file_seq #(
  parameter int REG_W     = 32,
  parameter int NREG      = 32,
  parameter int MAX_LMUL  = 8,
  parameter int BEAT_REGS = 2,
  localparam int PORT_W   = MAX_LMUL * REG_W,
  localparam int SEL_W    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            vlmul,
  input  logic [SEL_W-1:0]      op0_sel,
  input  logic [SEL_W-1:0]      op1_sel,
  output logic [PORT_W-1:0]     op0_out,
  output logic [PORT_W-1:0]     op1_out,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [SEL_W-1:0]      wb_sel,
  input  logic [2:0]            wb_vlmul,
  input  logic [MAX_LMUL-1:0]   wb_mask,
  input  logic [PORT_W-1:0]     wb_in,
  output logic                  wb_done,
  input  logic                  rsv_valid,
  input  logic [SEL_W-1:0]      rsv_sel,
  input  logic [2:0]            rsv_vlmul,
  output logic [NREG-1:0]       busy,
  output logic                  misalign,
  output logic [NREG*REG_W-1:0] dbg_regs
);

  localparam int CNT_W = $clog2(MAX_LMUL) + 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  // Fractional encodings (1xx) occupy a single register.
  function automatic logic [CNT_W-1:0] grp(
    input logic [2:0] v
  );
    int g;
    g = v[2] ? 1 : (1 << v[1:0]);
    if (g > MAX_LMUL) g = MAX_LMUL;
    return CNT_W'(g);
  endfunction

  function automatic logic [SEL_W-1:0] amask(
    input logic [CNT_W-1:0] g
  );
    return SEL_W'(g) - SEL_W'(1);
  endfunction

  state_t              r_state;
  state_t              w_state_nx;

  logic [REG_W-1:0]    r_rf [NREG];
  logic [REG_W-1:0]    w_rf_nx [NREG];
  logic [PORT_W-1:0]   r_op0;
  logic [PORT_W-1:0]   r_op1;
  logic [NREG-1:0]     r_busy;
  logic                r_done;
  logic                r_mis;

  logic [SEL_W-1:0]    r_base;
  logic [CNT_W-1:0]    r_g;
  logic [CNT_W-1:0]    r_beat;
  logic [MAX_LMUL-1:0] r_mask;
  logic [PORT_W-1:0]   r_data;

  logic [CNT_W-1:0]    w_g_rd;
  logic [SEL_W-1:0]    w_b0;
  logic [SEL_W-1:0]    w_b1;
  logic [CNT_W-1:0]    w_wb_g;
  logic [SEL_W-1:0]    w_wb_base;
  logic                w_wb_mis;
  logic [CNT_W-1:0]    w_rsv_g;
  logic [SEL_W-1:0]    w_rsv_base;
  logic                w_rsv_mis;

  logic                w_ready;
  logic                w_acc;
  logic                w_act;
  logic                w_last;
  logic [SEL_W-1:0]    w_base;
  logic [CNT_W-1:0]    w_g;
  logic [CNT_W-1:0]    w_beat;
  logic [MAX_LMUL-1:0] w_mask;
  logic [PORT_W-1:0]   w_data;

  logic [NREG-1:0]     w_clr;
  logic [NREG-1:0]     w_set;
  logic [PORT_W-1:0]   w_op0_nx;
  logic [PORT_W-1:0]   w_op1_nx;

  assign w_g_rd     = grp(vlmul);
  assign w_b0       = op0_sel & ~amask(w_g_rd);
  assign w_b1       = op1_sel & ~amask(w_g_rd);

  assign w_wb_g     = grp(wb_vlmul);
  assign w_wb_base  = wb_sel & ~amask(w_wb_g);
  assign w_wb_mis   = |(wb_sel & amask(w_wb_g));

  assign w_rsv_g    = grp(rsv_vlmul);
  assign w_rsv_base = rsv_sel & ~amask(w_rsv_g);
  assign w_rsv_mis  = |(rsv_sel & amask(w_rsv_g));

  assign w_ready = (r_state == S_IDLE) & ~reset;
  assign w_acc   = wb_valid & w_ready;
  assign w_act   = w_acc | (r_state == S_BURST);

  // Beat 0 commits straight from the inputs at the accept edge;
  // later beats come from the latched copy.
  assign w_base = w_acc ? w_wb_base : r_base;
  assign w_g    = w_acc ? w_wb_g    : r_g;
  assign w_beat = w_acc ? '0        : r_beat;
  assign w_mask = w_acc ? wb_mask   : r_mask;
  assign w_data = w_acc ? wb_in     : r_data;

  assign w_last = w_act &&
    ((int'(w_beat) + 1) * BEAT_REGS >= int'(w_g));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && (w_wb_g > CNT_W'(BEAT_REGS)))
          w_state_nx = S_BURST;
      end
      S_BURST: begin
        if (w_last) w_state_nx = S_IDLE;
      end
    endcase
  end

  // Current beat: write masked registers, clear busy regardless of mask.
  always_comb begin
    int lo;
    w_rf_nx = r_rf;
    w_clr   = '0;
    lo      = int'(w_beat) * BEAT_REGS;
    for (int k = 0; k < MAX_LMUL; k++) begin
      if (w_act && k >= lo && k < lo + BEAT_REGS &&
          k < int'(w_g)) begin
        w_clr[w_base + SEL_W'(k)] = 1'b1;
        if (w_mask[k])
          w_rf_nx[w_base + SEL_W'(k)] = w_data[k*REG_W +: REG_W];
      end
    end
  end

  always_comb begin
    w_set = '0;
    for (int k = 0; k < MAX_LMUL; k++) begin
      if (rsv_valid && k < int'(w_rsv_g))
        w_set[w_rsv_base + SEL_W'(k)] = 1'b1;
    end
  end

  // Reads see this edge's writes (write-first).
  always_comb begin
    w_op0_nx = '0;
    w_op1_nx = '0;
    for (int k = 0; k < MAX_LMUL; k++) begin
      if (k < int'(w_g_rd)) begin
        w_op0_nx[k*REG_W +: REG_W] = w_rf_nx[w_b0 + SEL_W'(k)];
        w_op1_nx[k*REG_W +: REG_W] = w_rf_nx[w_b1 + SEL_W'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf   <= '{default: '0};
      r_op0  <= '0;
      r_op1  <= '0;
      r_busy <= '0;
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      r_base <= '0;
      r_g    <= '0;
      r_beat <= '0;
      r_mask <= '0;
      r_data <= '0;
    end else begin
      r_rf   <= w_rf_nx;
      r_op0  <= w_op0_nx;
      r_op1  <= w_op1_nx;
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_done <= w_last;
      r_mis  <= (w_acc & w_wb_mis) | (rsv_valid & w_rsv_mis);
      if (w_acc) begin
        r_base <= w_wb_base;
        r_g    <= w_wb_g;
        r_beat <= CNT_W'(1);
        r_mask <= wb_mask;
        r_data <= wb_in;
      end else if (r_state == S_BURST) begin
        r_beat <= r_beat + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_dbg
    assign dbg_regs[gi*REG_W +: REG_W] = r_rf[gi];
  end

  assign op0_out  = r_op0;
  assign op1_out  = r_op1;
  assign wb_ready = w_ready;
  assign wb_done  = r_done;
  assign busy     = r_busy;
  assign misalign = r_mis;

endmodule

// File: tb/tb_vector_register_file_seq.sv
// Directed bench for vector_register_file_seq.
// Linear stimulus, immediate-assertion checks.
module tb_vector_register_file_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    vlmul;
  logic [4:0]    op0_sel;
  logic [4:0]    op1_sel;
  logic [255:0]  op0_out;
  logic [255:0]  op1_out;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_sel;
  logic [2:0]    wb_vlmul;
  logic [7:0]    wb_mask;
  logic [255:0]  wb_in;
  logic          wb_done;
  logic          rsv_valid;
  logic [4:0]    rsv_sel;
  logic [2:0]    rsv_vlmul;
  logic [31:0]   busy;
  logic          misalign;
  logic [1023:0] dbg_regs;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  vector_register_file_seq dut (
    .clk       (clk),
    .reset     (reset),
    .vlmul     (vlmul),
    .op0_sel   (op0_sel),
    .op1_sel   (op1_sel),
    .op0_out   (op0_out),
    .op1_out   (op1_out),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_sel    (wb_sel),
    .wb_vlmul  (wb_vlmul),
    .wb_mask   (wb_mask),
    .wb_in     (wb_in),
    .wb_done   (wb_done),
    .rsv_valid (rsv_valid),
    .rsv_sel   (rsv_sel),
    .rsv_vlmul (rsv_vlmul),
    .busy      (busy),
    .misalign  (misalign),
    .dbg_regs  (dbg_regs)
  );

  task automatic chk(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] words(
    input logic [31:0] s,
    input int          n
  );
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      v[k*32 +: 32] = s + 32'(k);
    return v;
  endfunction

  initial begin
    reset     = 1'b1;
    vlmul     = 3'b011;
    op0_sel   = '0;
    op1_sel   = '0;
    wb_valid  = 1'b0;
    wb_sel    = '0;
    wb_vlmul  = '0;
    wb_mask   = '0;
    wb_in     = '0;
    rsv_valid = 1'b0;
    rsv_sel   = '0;
    rsv_vlmul = '0;

    step();
    step();
    chk("rst_ready", 256'(wb_ready), 256'd0);
    chk("rst_op0", op0_out, 256'd0);
    chk("rst_op1", op1_out, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(wb_done), 256'd0);
    chk("rst_mis", 256'(misalign), 256'd0);

    reset = 1'b0;
    step();
    chk("ready_after_rst", 256'(wb_ready), 256'd1);
    chk("read_r0_7", op0_out, 256'd0);

    // 8-register burst to r8
    wb_valid = 1'b1;
    wb_sel   = 5'd8;
    wb_vlmul = 3'b011;
    wb_mask  = 8'hFF;
    wb_in    = words(32'hA0, 8);
    step();
    wb_valid = 1'b0;
    wb_in    = '1;
    wb_mask  = '0;
    wb_sel   = '0;
    chk("b_ready0", 256'(wb_ready), 256'd0);
    chk("b_done0", 256'(wb_done), 256'd0);
    step();
    chk("b_ready1", 256'(wb_ready), 256'd0);
    chk("b_done1", 256'(wb_done), 256'd0);
    step();
    chk("b_ready2", 256'(wb_ready), 256'd0);
    chk("b_done2", 256'(wb_done), 256'd0);
    step();
    chk("b_ready3", 256'(wb_ready), 256'd1);
    chk("b_done3", 256'(wb_done), 256'd1);
    op0_sel = 5'd8;
    vlmul   = 3'b011;
    step();
    chk("b_done4", 256'(wb_done), 256'd0);
    chk("b_read", op0_out, words(32'hA0, 8));

    // masked pair writes, forwarding
    wb_valid = 1'b1;
    wb_sel   = 5'd4;
    wb_vlmul = 3'b001;
    wb_mask  = 8'h03;
    wb_in    = {192'd0, 32'h55, 32'h44};
    step();
    chk("m_ready", 256'(wb_ready), 256'd1);
    chk("m_done1", 256'(wb_done), 256'd1);
    wb_mask = 8'h01;
    wb_in   = {192'd0, 32'h22, 32'h11};
    op0_sel = 5'd4;
    op1_sel = 5'd4;
    vlmul   = 3'b001;
    step();
    wb_valid = 1'b0;
    chk("m_fwd0", op0_out, {192'd0, 32'h55, 32'h11});
    chk("m_fwd1", op1_out, {192'd0, 32'h55, 32'h11});
    chk("m_done2", 256'(wb_done), 256'd1);
    step();
    chk("m_done3", 256'(wb_done), 256'd0);
    chk("m_r4", 256'(dbg_regs[4*32 +: 32]), 256'h11);
    chk("m_r5", 256'(dbg_regs[5*32 +: 32]), 256'h55);

    // scoreboard
    rsv_valid = 1'b1;
    rsv_sel   = 5'd16;
    rsv_vlmul = 3'b010;
    step();
    rsv_valid = 1'b0;
    chk("s_busy_rsv", 256'(busy), 256'h000F0000);
    chk("s_mis0", 256'(misalign), 256'd0);
    wb_valid = 1'b1;
    wb_sel   = 5'd16;
    wb_vlmul = 3'b010;
    wb_mask  = 8'h0F;
    wb_in    = words(32'h100, 4);
    step();
    wb_valid = 1'b0;
    chk("s_busy0", 256'(busy), 256'h000C0000);
    chk("s_ready0", 256'(wb_ready), 256'd0);
    rsv_valid = 1'b1;
    rsv_sel   = 5'd18;
    rsv_vlmul = 3'b000;
    step();
    rsv_valid = 1'b0;
    chk("s_busy1", 256'(busy), 256'h00040000);
    chk("s_done", 256'(wb_done), 256'd1);
    chk("s_ready1", 256'(wb_ready), 256'd1);
    chk("s_r19", 256'(dbg_regs[19*32 +: 32]), 256'h103);

    // misaligned write, fractional read
    wb_valid = 1'b1;
    wb_sel   = 5'd3;
    wb_vlmul = 3'b010;
    wb_mask  = 8'h0F;
    wb_in    = words(32'hB0, 4);
    step();
    wb_valid = 1'b0;
    chk("a_mis", 256'(misalign), 256'd1);
    chk("a_ready", 256'(wb_ready), 256'd0);
    step();
    chk("a_mis_clr", 256'(misalign), 256'd0);
    chk("a_done", 256'(wb_done), 256'd1);
    op0_sel = 5'd0;
    op1_sel = 5'd2;
    vlmul   = 3'b100;
    step();
    chk("a_op1", op1_out, {224'd0, 32'hB2});
    chk("a_op0", op0_out, {224'd0, 32'hB0});

    // misaligned reservation
    rsv_valid = 1'b1;
    rsv_sel   = 5'd5;
    rsv_vlmul = 3'b001;
    step();
    rsv_valid = 1'b0;
    chk("r_mis", 256'(misalign), 256'd1);
    chk("r_busy", 256'(busy), 256'h00040030);
    step();
    chk("r_mis_clr", 256'(misalign), 256'd0);

    // reset during burst
    wb_valid = 1'b1;
    wb_sel   = 5'd24;
    wb_vlmul = 3'b011;
    wb_mask  = 8'hFF;
    wb_in    = words(32'hC0, 8);
    step();
    wb_valid = 1'b0;
    chk("x_r24", 256'(dbg_regs[24*32 +: 32]), 256'hC0);
    step();
    reset = 1'b1;
    #1;
    chk("x_ready_rst", 256'(wb_ready), 256'd0);
    step();
    chk("x_busy", 256'(busy), 256'd0);
    chk("x_done", 256'(wb_done), 256'd0);
    chk("x_dbg_hi", dbg_regs[1023:768], 256'd0);
    chk("x_dbg_lo", dbg_regs[255:0], 256'd0);
    chk("x_op0", op0_out, 256'd0);
    reset = 1'b0;
    step();
    chk("x_ready", 256'(wb_ready), 256'd1);
    chk("x_done1", 256'(wb_done), 256'd0);
    chk("x_dbg_hi1", dbg_regs[1023:768], 256'd0);
    step();
    chk("x_done2", 256'(wb_done), 256'd0);
    chk("x_dbg_hi2", dbg_regs[1023:768], 256'd0);
    chk("x_busy2", 256'(busy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
